flip_flop: RTL and testbench

// - Generic N-bit D-type register with synchronous, active-high reset.
// - Basic storage primitive for the datapath: pipeline registers, PC, and

---
 rtl/flip_flop.sv | 39 +++
 tb/tb_flip_flop.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/flip_flop.sv
// flip_flop: generic N-bit D-type register with synchronous, active-high reset.
// q follows d on every rising clk edge; reset loads RESET_VALUE and wins over d.
// No enable and no combinational path from d or reset to q.
// Optional macro FLIP_FLOP_ASSERT_EN adds simulation-only X/Z checks on
// reset and d at each rising edge; functional behaviour is identical either way.
module flip_flop #(
    parameter int unsigned    N           = 32,
    parameter logic [N-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // State register: reset has priority, otherwise capture d.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

`ifdef FLIP_FLOP_ASSERT_EN
`ifndef SYNTHESIS
    // Flag unknown control or data at the sampling edge (d only matters when not in reset).
    always @(posedge clk) begin
        if ($isunknown(reset)) begin
            $error("flip_flop: reset is X/Z at rising clk edge");
        end else if (!reset && $isunknown(d)) begin
            $error("flip_flop: d is X/Z at rising clk edge while reset is low");
        end
    end
`endif
`else
`endif

endmodule

// File: tb/tb_flip_flop.sv
// tb_flip_flop: directed, table-driven checks of flip_flop at N=32, N=8 (RESET_VALUE=8'h3C)
// and N=1, plus hand-written sequences for between-edge reset and data activity.
module tb_flip_flop;

    logic        clk;
    logic        reset;
    logic [31:0] d32;
    logic [7:0]  d8;
    logic [0:0]  d1;
    logic [31:0] q32;
    logic [7:0]  q8;
    logic [0:0]  q1;

    int unsigned passed;
    int unsigned total;

    flip_flop #(.N(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .d     (d32),
        .q     (q32)
    );

    flip_flop #(.N(8), .RESET_VALUE(8'h3C)) dut8 (
        .clk   (clk),
        .reset (reset),
        .d     (d8),
        .q     (q8)
    );

    flip_flop #(.N(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d1),
        .q     (q1)
    );

    // 10 ns clock period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        reset;
        logic [31:0] d32;
        logic [7:0]  d8;
        logic [0:0]  d1;
        logic [31:0] e32;
        logic [7:0]  e8;
        logic [0:0]  e1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Wait for the next rising edge, then move 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;

        //          reset  d32            d8     d1    e32            e8     e1
        vecs[0] = '{1'b1, 32'hDEAD_BEEF, 8'h99, 1'b1, 32'h0000_0000, 8'h3C, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 8'hFF, 1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b1};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b1, 32'h0000_0000, 8'h3C, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 32'h0000_0000, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 32'hA5A5_5A5A, 8'hA5, 1'b1, 32'hA5A5_5A5A, 8'hA5, 1'b1};
        vecs[5] = '{1'b1, 32'h1234_5678, 8'h78, 1'b1, 32'h0000_0000, 8'h3C, 1'b0};
        vecs[6] = '{1'b0, 32'h1234_5678, 8'h78, 1'b1, 32'h1234_5678, 8'h78, 1'b1};

        for (int i = 0; i < 7; i++) begin
            if (i > 0) #1;
            reset = vecs[i].reset;
            d32   = vecs[i].d32;
            d8    = vecs[i].d8;
            d1    = vecs[i].d1;
            if (i > 0) begin
                // Inputs changed between edges: q must still show the previous result.
                #1;
                check($sformatf("v%0d_pre_q32", i), q32, vecs[i-1].e32);
                check($sformatf("v%0d_pre_q8", i), {24'h0, q8}, {24'h0, vecs[i-1].e8});
            end
            tick();
            check($sformatf("v%0d_q32", i), q32, vecs[i].e32);
            check($sformatf("v%0d_q8", i), {24'h0, q8}, {24'h0, vecs[i].e8});
            check($sformatf("v%0d_q1", i), {31'h0, q1}, {31'h0, vecs[i].e1});
        end

        // Reset pulsed entirely between two edges: no reset occurs.
        reset = 1'b1;
        #2;
        check("pulse_mid_q32", q32, 32'h1234_5678);
        reset = 1'b0;
        tick();
        check("pulse_after_q32", q32, 32'h1234_5678);
        check("pulse_after_q8", {24'h0, q8}, 32'h0000_0078);

        // d toggled between edges: q changes only at the rising edge.
        d32 = 32'hCAFE_F00D;
        #2;
        check("toggle_a_q32", q32, 32'h1234_5678);
        d32 = 32'h0BAD_C0DE;
        #2;
        check("toggle_b_q32", q32, 32'h1234_5678);
        d32 = 32'h1111_2222;
        d8  = 8'h5A;
        d1  = 1'b0;
        tick();
        check("toggle_edge_q32", q32, 32'h1111_2222);
        check("toggle_edge_q8", {24'h0, q8}, 32'h0000_005A);
        check("toggle_edge_q1", {31'h0, q1}, 32'h0);

        // Reset over one edge, then q holds RESET_VALUE after reset drops until the next edge.
        reset = 1'b1;
        tick();
        check("rst_q32", q32, 32'h0000_0000);
        check("rst_q8", {24'h0, q8}, 32'h0000_003C);
        reset = 1'b0;
        d32   = 32'h55AA_55AA;
        d8    = 8'hC3;
        d1    = 1'b1;
        #2;
        check("rst_hold_q32", q32, 32'h0000_0000);
        check("rst_hold_q8", {24'h0, q8}, 32'h0000_003C);
        tick();
        check("rst_load_q32", q32, 32'h55AA_55AA);
        check("rst_load_q8", {24'h0, q8}, 32'h0000_00C3);
        check("rst_load_q1", {31'h0, q1}, 32'h1);

        // No enable: q holds across edges only because d is held steady.
        tick();
        check("steady_q32", q32, 32'h55AA_55AA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
